// File: rtl/twiddle_factor_rom.sv
// ---------------------------------------------------------------------------
// twiddle_factor_rom
//
// Registered lookup of the complex twiddle factor
//   W_512^k = cos(2*pi*k/512) - j*sin(2*pi*k/512),  k = 0..511
// in signed Q1.23 per component (round-to-nearest, +1.0 saturates to 0x7FFFFF).
//
// Only the half-period (k = 0..255) is stored. The upper half is produced by
// negating both components, since W^(k+256) = -W^k. The half-period table is
// itself folded from a 129-entry quarter-wave sine table built at elaboration.
//
// Ports:
//   clk              in   1           rising-edge clock
//   rst_n            in   1           asynchronous active-low reset
//   addr             in   ADDR_WIDTH  twiddle index k (unsigned)
//   twiddle_factor_q out  DATA_WIDTH  {real[47:24], imag[23:0]}, one-cycle latency
// ---------------------------------------------------------------------------
module twiddle_factor_rom #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] twiddle_factor_q
);

  localparam int COMP_W  = DATA_WIDTH / 2;
  localparam int QUARTER = 128;
  localparam int HALF    = 256;

  // Two's-complement negation of one component. The table never holds the
  // most negative code, so this cannot overflow.
  function automatic logic [COMP_W-1:0] neg_comp(input logic [COMP_W-1:0] v);
    return {COMP_W{1'b0}} - v;
  endfunction

  // sin(pi*j/256) for j in 0..128, scaled by 2^23, rounded to nearest and
  // saturated at +1.0. Evaluated only with constant arguments, so it folds to
  // constants. A Taylor series is used instead of $sin so the table does not
  // depend on tool support for math system functions; with x <= pi/2 and
  // eleven terms the truncation error is far below one LSB.
  function automatic logic [COMP_W-1:0] sin_q23(input int j);
    real x;
    real term;
    real sum;
    int  val;
    x    = 3.14159265358979323846 * $itor(j) / 256.0;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / ($itor(2 * n) * $itor(2 * n + 1));
      sum  = sum + term;
    end
    // Argument is non-negative, so truncating after +0.5 rounds to nearest.
    val = $rtoi(sum * 8388608.0 + 0.5);
    if (val > 32'sd8388607) begin
      val = 32'sd8388607;
    end else begin
      val = val;
    end
    return val[COMP_W-1:0];
  endfunction

  logic [COMP_W-1:0] sin_tab [QUARTER+1];
  logic [COMP_W-1:0] base_re [HALF];
  logic [COMP_W-1:0] base_im [HALF];

  logic [7:0]            idx_s;
  logic [COMP_W-1:0]     re_s;
  logic [COMP_W-1:0]     im_s;
  logic [DATA_WIDTH-1:0] twiddle_factor_d;

  for (genvar g = 0; g <= QUARTER; g++) begin : g_sin
    assign sin_tab[g] = sin_q23(g);
  end

  // Fold the quarter-wave sine into the half period (angle theta = pi*i/256):
  //   i <= 128 : cos = sin(pi*(128-i)/256),  sin = sin(pi*i/256)
  //   i >  128 : cos = -sin(pi*(i-128)/256), sin = sin(pi*(256-i)/256)
  // The imaginary part carries -sin.
  for (genvar g = 0; g < HALF; g++) begin : g_base
    if (g <= QUARTER) begin : g_first_quadrant
      assign base_re[g] = sin_tab[QUARTER-g];
      assign base_im[g] = neg_comp(sin_tab[g]);
    end else begin : g_second_quadrant
      assign base_re[g] = neg_comp(sin_tab[g-QUARTER]);
      assign base_im[g] = neg_comp(sin_tab[HALF-g]);
    end
  end

  // Half-table read plus negation of both components for the upper half.
  always_comb begin
    idx_s = addr[7:0];
    re_s  = base_re[idx_s];
    im_s  = base_im[idx_s];
    if (addr[ADDR_WIDTH-1]) begin
      twiddle_factor_d = {neg_comp(re_s), neg_comp(im_s)};
    end else begin
      twiddle_factor_d = {re_s, im_s};
    end
  end

  // Output register: the only state in the block; cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      twiddle_factor_q <= {DATA_WIDTH{1'b0}};
    end else begin
      twiddle_factor_q <= twiddle_factor_d;
    end
  end

endmodule

// File: tb/tb_twiddle_factor_rom.sv
// ---------------------------------------------------------------------------
// Testbench for twiddle_factor_rom: reference-value table, latency/hold and
// reset sequences, exhaustive sweep against ideal cos/-sin, symmetry-pair
// check, random addresses, and asynchronous reset mid-stream.
// ---------------------------------------------------------------------------
module tb_twiddle_factor_rom;

  localparam int AW = 9;
  localparam int DW = 48;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] tf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs [9];
  logic [DW-1:0] sweep_q [512];

  twiddle_factor_rom #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .addr             (addr),
    .twiddle_factor_q (tf)
  );

  always #5 clk = ~clk;

  // Exact comparison.
  task automatic check_eq(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // Compare against ideal cos/-sin scaled by 2^23 within +/-1 LSB per component.
  task automatic check_ideal(input int k, input logic [DW-1:0] got);
    real ire, iim, dre, dim;
    int  are, aim;
    logic signed [23:0] gre, gim;
    ire = $cos(2.0 * PI * $itor(k) / 512.0) * 8388608.0;
    iim = -$sin(2.0 * PI * $itor(k) / 512.0) * 8388608.0;
    gre = got[47:24];
    gim = got[23:0];
    are = gre;
    aim = gim;
    dre = $itor(are) - ire;
    dim = $itor(aim) - iim;
    if (dre < 0.0) dre = -dre;
    if (dim < 0.0) dim = -dim;
    checks++;
    if (dre > 1.0 || dim > 1.0 || $isunknown(got)) begin
      errors++;
      $display("FAIL ideal[k=%0d]: got re=%0d im=%0d (%h), required re=%f im=%f +/-1",
               k, are, aim, got, ire, iim);
    end
  endtask

  // Present an address away from the active edge, then sample after the edge.
  task automatic apply(input logic [AW-1:0] a);
    @(negedge clk);
    addr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] exp_neg;
    logic [23:0]   cre, cim;
    int            k;

    vecs[0] = '{a: 9'd0,   exp: 48'h7FFFFF000000};
    vecs[1] = '{a: 9'd1,   exp: 48'h7FFD88FE6DE3};
    vecs[2] = '{a: 9'd64,  exp: 48'h5A827AA57D86};
    vecs[3] = '{a: 9'd128, exp: 48'h000000800001};
    vecs[4] = '{a: 9'd255, exp: 48'h800278FE6DE3};
    vecs[5] = '{a: 9'd256, exp: 48'h800001000000};
    vecs[6] = '{a: 9'd257, exp: 48'h80027801921D};
    vecs[7] = '{a: 9'd384, exp: 48'h0000007FFFFF};
    vecs[8] = '{a: 9'd511, exp: 48'h7FFD8801921D};

    // Reset held for two edges with addr = 0.
    rst_n = 1'b0;
    addr  = 9'd0;
    #1;
    check_eq("reset_async", tf, 48'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("reset_hold", tf, 48'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("reset_release", tf, 48'h7FFFFF000000);

    // Latency and hold: addr=0 then addr=1 on consecutive cycles.
    apply(9'd0);
    check_eq("lat_addr0", tf, 48'h7FFFFF000000);
    @(negedge clk);
    addr = 9'd1;
    #1;
    check_eq("lat_before_edge", tf, 48'h7FFFFF000000);
    @(posedge clk);
    #1;
    check_eq("lat_addr1", tf, 48'h7FFD88FE6DE3);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("hold_addr1", tf, 48'h7FFD88FE6DE3);
    end

    // Reference-value table.
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].a);
      check_eq($sformatf("vec_k%0d", vecs[i].a), tf, vecs[i].exp);
    end

    // Exhaustive back-to-back sweep against ideal math.
    for (int i = 0; i < 512; i++) begin
      apply(i[AW-1:0]);
      check_ideal(i, tf);
      sweep_q[i] = tf;
    end

    // Symmetry pairs must be exact component-wise negations.
    for (int i = 0; i < 256; i++) begin
      cre     = sweep_q[i][47:24];
      cim     = sweep_q[i][23:0];
      exp_neg = {24'd0 - cre, 24'd0 - cim};
      check_eq($sformatf("sym_k%0d", i + 256), sweep_q[i + 256], exp_neg);
    end

    // Random addresses.
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(511, 0);
      apply(k[AW-1:0]);
      check_ideal(k, tf);
    end

    // Asynchronous reset mid-stream, between clock edges.
    apply(9'd300);
    check_ideal(300, tf);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midstream_reset_async", tf, 48'h0);
    @(posedge clk);
    #1;
    check_eq("midstream_reset_hold", tf, 48'h0);
    @(negedge clk);
    rst_n = 1'b1;
    addr  = 9'd301;
    @(posedge clk);
    #1;
    check_ideal(301, tf);
    apply(9'd302);
    check_ideal(302, tf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/twiddle_factor_rom.md
Name: twiddle_factor_rom

Overview:
- Synchronous read-only lookup of complex twiddle factors W_512^k = cos(2πk/512) − j·sin(2πk/512) for k = 0..511, feeding the FFT butterfly datapath.
- Physically stores only the 256-entry half-period table (k = 0..255).
- Addresses 256..511 are served by negation symmetry: W_512^(k+256) = −W_512^k.
- Output is registered, giving one-cycle read latency.

Parameters:
- ADDR_WIDTH, 9, twiddle index width (512 entries); MSB selects the negated half.
- DATA_WIDTH, 48, packed complex output width; each component is DATA_WIDTH/2 = 24 bits. Only the default values are required to be supported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- addr  input  ADDR_WIDTH  twiddle index k, unsigned 0..511.
- twiddle_factor_q  output  DATA_WIDTH  registered twiddle value: [47:24] = real part, [23:0] = imaginary part.

Behaviour:
- Number format: each component is signed two's-complement Q1.23 (value × 2^23).
  - Table entries are round-to-nearest of cos(2πk/512) and −sin(2πk/512).
  - +1.0 saturates to 0x7FFFFF.
- Base table (k = 0..255, 256 entries):
  - real = cos term, imag = −sin term.
  - Built from a constant table or quarter-wave folding; either is acceptable if the output values match.
- Symmetry: let i = addr[7:0].
  - addr[8] = 0: output is {re[i], im[i]}.
  - addr[8] = 1: output is {−re[i], −im[i]}, negated per 24-bit component in two's complement.
  - −0x000000 = 0x000000. −0x7FFFFF = 0x800001; 0x800000 never occurs.
- Latency:
  - addr is sampled on a rising clk edge; twiddle_factor_q reflects it after that same edge, so it is valid one cycle after addr is presented.
  - Output holds until the next edge.
  - Back-to-back addresses give one result per cycle; there is no handshake and no enable.
- Reset:
  - rst_n low asynchronously forces twiddle_factor_q to 0 and holds it at 0 while low.
  - The first edge with rst_n high loads the value for the current addr.
  - Reset asserted mid-stream clears the output immediately.
- No internal state besides the output register. Output depends only on the addr captured at the last edge.
- Reference values (hex, real|imag), exact with the rounding rule above:
  - k=0: 7FFFFF|000000
  - k=1: 7FFD88|FE6DE3
  - k=64: 5A827A|A57D86
  - k=128: 000000|800001
  - k=255: 800278|FE6DE3
  - k=256: 800001|000000
  - k=257: 800278|01921D
  - k=511: 7FFD88|01921D
- Verification tolerance against ideal math: ±1 LSB per component. Symmetry pairs (k, k+256) must be exact negations.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with addr=0 -> twiddle_factor_q = 0x000000000000 throughout. Release reset, wait one edge -> 7FFFFF000000.
- Latency: apply addr=0, then addr=1 on consecutive cycles -> output is 7FFFFF000000, then 7FFD88FE6DE3, each one edge after the address is sampled. Output stays stable while addr is held.
- Half-period boundary: addr=255 -> 800278FE6DE3; addr=256 -> 800001000000.
- Symmetry: addr=257 -> 80027801921D (exact negation of addr=1); addr=511 -> 7FFD8801921D (conjugate of W^1).
- Quadrant points: addr=64 -> 5A827AA57D86; addr=128 -> 000000800001; addr=384 -> 0000007FFFFF.
- Exhaustive sweep:
  - Step addr 0..511, one per cycle; compare each output, one cycle later, against ideal cos/−sin × 2^23 within ±1 LSB.
  - Check that output(k+256) == −output(k) exactly for all k < 256.
  - Assert rst_n mid-sweep -> output goes to 0 immediately, without waiting for a clock edge.
